// File: rtl/one_hot_state_monitor.sv
// Purpose : watches a 4-state one-hot ring FSM (state_in/out_in) and flags the first protocol error.
// Latency : error flag/code and FAULT state appear one cycle after the offending sample; lap_count updates one cycle after the wrap.
// Backpr. : none; passive observer that samples every cycle and never stalls the upstream FSM.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (wins over clear)
//   state_in   one-hot state from the upstream ring FSM
//   out_in     encoded output from the upstream FSM (must equal the state's bit index)
//   clear      synchronous soft clear of errors, counters and tracking (wins over errors)
//   mon_state  00 SYNC, 01 RUN, 10 FAULT
//   err        sticky error flag
//   err_code   001 not one-hot, 010 illegal transition, 011 out_in mismatch, 100 stall
//   lap_count  completed rings (1000->0001 wraps), saturating
//
// Build option: define ONEHOT_MON_STALL_EN to build the dwell counter and stall check (err_code 100).

module one_hot_state_monitor #(
    parameter int LAP_W     = 8,
    parameter int DWELL_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state_in,
    input  logic [1:0]       out_in,
    input  logic             clear,
    output logic [1:0]       mon_state,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [LAP_W-1:0] lap_count
);

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } mon_t;

    mon_t             cur_st, nxt_st;
    logic [3:0]       prev_q, prev_d;
    logic             err_d;
    logic [2:0]       code_d;
    logic [LAP_W-1:0] lap_d;

    // ---------------- per-sample checks ----------------
    logic       onehot;
    logic       legal_tr;
    logic       out_ok;
    logic       lap_wrap;
    logic       stall;
    logic [3:0] succ;
    logic [1:0] exp_out;
    logic [2:0] det_code;

    assign onehot   = (state_in != 4'd0) && ((state_in & (state_in - 4'd1)) == 4'd0);
    assign succ     = {prev_q[2:0], prev_q[3]};
    assign legal_tr = (state_in == prev_q) || (state_in == succ);
    assign out_ok   = (out_in == exp_out);
    assign lap_wrap = (prev_q == 4'b1000) && (state_in == 4'b0001);

    always_comb begin
        exp_out = 2'b00;
        case (state_in)
            4'b0001: exp_out = 2'b00;
            4'b0010: exp_out = 2'b01;
            4'b0100: exp_out = 2'b10;
            4'b1000: exp_out = 2'b11;
            default: exp_out = 2'b00;
        endcase
    end

`ifdef ONEHOT_MON_STALL_EN
    // Counter only needs to reach DWELL_MAX+1, the first value that trips the stall.
    localparam int DW_W = $clog2(DWELL_MAX + 2);
    localparam logic [DW_W-1:0] DW_LIM = DW_W'(DWELL_MAX);

    logic [DW_W-1:0] dwell_q, dwell_d, held;

    // Number of consecutive samples of the current value, including this one.
    assign held  = (state_in == prev_q) ? (dwell_q + DW_W'(1)) : DW_W'(1);
    assign stall = (held > DW_LIM);
`else
    assign stall = 1'b0;
`endif

    // Priority order: one-hot, transition, output, stall.
    always_comb begin
        det_code = 3'b000;
        if (!onehot)        det_code = 3'b001;
        else if (!legal_tr) det_code = 3'b010;
        else if (!out_ok)   det_code = 3'b011;
        else if (stall)     det_code = 3'b100;
    end

    // ---------------- next-state / next-output ----------------
    always_comb begin
        nxt_st = cur_st;
        prev_d = prev_q;
        err_d  = err;
        code_d = err_code;
        lap_d  = lap_count;
`ifdef ONEHOT_MON_STALL_EN
        dwell_d = dwell_q;
`endif
        if (clear) begin
            // Clear beats any error detected in the same sample.
            nxt_st = SYNC;
            prev_d = 4'b0001;
            err_d  = 1'b0;
            code_d = 3'b000;
            lap_d  = '0;
`ifdef ONEHOT_MON_STALL_EN
            dwell_d = '0;
`endif
        end else begin
            case (cur_st)
                SYNC: begin
                    if (state_in == 4'b0001 && out_in == 2'b00)
                        nxt_st = RUN;
                end
                RUN: begin
                    if (det_code != 3'b000) begin
                        // Tracking freezes on error; a wrap with a bad out_in is not a lap.
                        nxt_st = FAULT;
                        err_d  = 1'b1;
                        code_d = det_code;
                    end else begin
                        prev_d = state_in;
`ifdef ONEHOT_MON_STALL_EN
                        dwell_d = held;
`endif
                        if (lap_wrap && !(&lap_count))
                            lap_d = lap_count + LAP_W'(1);
                    end
                end
                FAULT: begin
                    nxt_st = FAULT;
                end
                default: begin
                    nxt_st = SYNC;
                end
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st    <= SYNC;
            prev_q    <= 4'b0001;
            err       <= 1'b0;
            err_code  <= 3'b000;
            lap_count <= '0;
`ifdef ONEHOT_MON_STALL_EN
            dwell_q   <= '0;
`endif
        end else begin
            cur_st    <= nxt_st;
            prev_q    <= prev_d;
            err       <= err_d;
            err_code  <= code_d;
            lap_count <= lap_d;
`ifdef ONEHOT_MON_STALL_EN
            dwell_q   <= dwell_d;
`endif
        end
    end

    assign mon_state = cur_st;

endmodule

// File: tb/tb_one_hot_state_monitor.sv
// Purpose : self-checking bench for one_hot_state_monitor (directed scenarios plus randomized ring traffic).
// Latency : every step drives one sample and compares all outputs 1 time unit after the sampling edge.
// Backpr. : none; the DUT is a passive observer.

module tb_one_hot_state_monitor;

    localparam int LAP_W     = 8;
    localparam int DWELL_MAX = 4;
    localparam int LAP_MAX   = (1 << LAP_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic [3:0]       state_in = 4'b0001;
    logic [1:0]       out_in = 2'b00;
    logic [1:0]       mon_state;
    logic             err;
    logic [2:0]       err_code;
    logic [LAP_W-1:0] lap_count;

    one_hot_state_monitor #(.LAP_W(LAP_W), .DWELL_MAX(DWELL_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .state_in  (state_in),
        .out_in    (out_in),
        .clear     (clear),
        .mon_state (mon_state),
        .err       (err),
        .err_code  (err_code),
        .lap_count (lap_count)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;

    // Reference model: ring position as an integer 0..3, monitor mode as 0/1/2.
    int m_mon  = 0;
    int m_err  = 0;
    int m_code = 0;
    int m_lap  = 0;
    int m_pos  = 0;   // position of the last accepted sample
    int m_held = 0;   // how many consecutive samples sat at m_pos

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int bitcount(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) if (s[i]) n++;
        return n;
    endfunction

    function automatic int position(input logic [3:0] s);
        int p = 0;
        for (int i = 0; i < 4; i++) if (s[i]) p = i;
        return p;
    endfunction

    task automatic model(input logic r, input logic c, input logic [3:0] s, input logic [1:0] o);
        int code, p, h;
        if (r || c) begin
            m_mon = 0; m_err = 0; m_code = 0; m_lap = 0; m_pos = 0; m_held = 0;
        end else if (m_mon == 0) begin
            if (s == 4'b0001 && o == 2'b00) m_mon = 1;
        end else if (m_mon == 1) begin
            code = 0;
            p = position(s);
            h = (p == m_pos) ? m_held + 1 : 1;
            if (bitcount(s) != 1)                          code = 1;
            else if (p != m_pos && p != (m_pos + 1) % 4)   code = 2;
            else if (int'(o) != p)                         code = 3;
`ifdef ONEHOT_MON_STALL_EN
            else if (h > DWELL_MAX)                        code = 4;
`endif
            if (code != 0) begin
                m_mon = 2; m_err = 1; m_code = code;
            end else begin
                if (m_pos == 3 && p == 0 && m_lap < LAP_MAX) m_lap++;
                m_pos  = p;
                m_held = h;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [3:0] s, input logic [1:0] o);
        reset = r; clear = c; state_in = s; out_in = o;
        @(posedge clk);
        model(r, c, s, o);
        #1;
        chk("mon_state", 32'(mon_state), 32'(m_mon));
        chk("err",       32'(err),       32'(m_err));
        chk("err_code",  32'(err_code),  32'(m_code));
        chk("lap_count", 32'(lap_count), 32'(m_lap));
    endtask

    // Legal sample at ring position p.
    task automatic ring(input int p);
        logic [3:0] s;
        s = 4'b0001 << p;
        step(1'b0, 1'b0, s, 2'(p));
    endtask

    task automatic laps(input int n);
        for (int k = 0; k < n; k++)
            for (int i = 1; i <= 4; i++) ring(i % 4);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 4'b0001, 2'b00);
        chk("rst_mon", 32'(mon_state), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_lap", 32'(lap_count), 32'd0);

        // Clean ring, three laps
        ring(0);
        chk("sync_to_run", 32'(mon_state), 32'd1);
        laps(3);
        chk("laps3_mon", 32'(mon_state), 32'd1);
        chk("laps3_err", 32'(err), 32'd0);
        chk("laps3_lap", 32'(lap_count), 32'd3);

        // Not one-hot, then a later legal sample must not change the code
        step(1'b0, 1'b0, 4'b0110, 2'b00);
        chk("onehot_code", 32'(err_code), 32'd1);
        chk("onehot_mon", 32'(mon_state), 32'd2);
        step(1'b0, 1'b0, 4'b0001, 2'b00);
        chk("sticky_code", 32'(err_code), 32'd1);
        chk("sticky_lap", 32'(lap_count), 32'd3);

        // Clear from FAULT
        step(1'b0, 1'b1, 4'b0001, 2'b00);
        chk("clr_mon", 32'(mon_state), 32'd0);
        chk("clr_lap", 32'(lap_count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);

        // Illegal jump 0010 -> 1000
        ring(0); ring(1);
        step(1'b0, 1'b0, 4'b1000, 2'b11);
        chk("jump_code", 32'(err_code), 32'd2);

        // out_in mismatch on 0100
        step(1'b0, 1'b1, 4'b0001, 2'b00);
        ring(0); ring(1);
        step(1'b0, 1'b0, 4'b0100, 2'b01);
        chk("outmm_code", 32'(err_code), 32'd3);

        // Hold 0010 for six samples
        step(1'b0, 1'b1, 4'b0001, 2'b00);
        ring(0);
        for (int i = 0; i < 6; i++) ring(1);
`ifdef ONEHOT_MON_STALL_EN
        chk("stall_code", 32'(err_code), 32'd4);
        chk("stall_mon", 32'(mon_state), 32'd2);
`else
        chk("nostall_err", 32'(err), 32'd0);
        chk("nostall_mon", 32'(mon_state), 32'd1);
`endif

        // Clear wins over a simultaneous error, then resync on 0001
        step(1'b0, 1'b1, 4'b0001, 2'b00);
        ring(0); ring(1);
        step(1'b0, 1'b1, 4'b0110, 2'b00);
        chk("clr_vs_err_err", 32'(err), 32'd0);
        chk("clr_vs_err_mon", 32'(mon_state), 32'd0);
        step(1'b0, 1'b0, 4'b0010, 2'b01);
        chk("no_resync_0010", 32'(mon_state), 32'd0);
        ring(0);
        chk("resync_mon", 32'(mon_state), 32'd1);

        // Wrap with out_in mismatch: error, no lap
        ring(1); ring(2); ring(3);
        step(1'b0, 1'b0, 4'b0001, 2'b01);
        chk("wrapmm_code", 32'(err_code), 32'd3);
        chk("wrapmm_lap", 32'(lap_count), 32'd0);

        // Reset mid-operation
        step(1'b0, 1'b1, 4'b0001, 2'b00);
        ring(0); laps(2); ring(1);
        step(1'b1, 1'b1, 4'b0110, 2'b00);
        chk("midrst_mon", 32'(mon_state), 32'd0);
        chk("midrst_lap", 32'(lap_count), 32'd0);

        // Lap saturation
        ring(0);
        laps(LAP_MAX + 4);
        chk("sat_lap", 32'(lap_count), 32'(LAP_MAX));
        chk("sat_err", 32'(err), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [3:0] s;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1'b1, 1'b0, 4'($urandom), 2'($urandom));
            end else if (r < 3) begin
                step(1'b0, 1'b1, 4'($urandom), 2'($urandom));
            end else if (r < 7) begin
                s = 4'($urandom);
                step(1'b0, 1'b0, s, 2'($urandom));
            end else if (m_mon != 1) begin
                step(1'b0, 1'b0, 4'b0001, 2'b00);
            end else if ($urandom_range(0, 3) == 0) begin
                ring(m_pos);
            end else begin
                ring((m_pos + 1) % 4);
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/one_hot_state_monitor.md
ONE_HOT_STATE_MONITOR -- requirements
Module: one_hot_state_monitor

Interface
REQ-001 SHALL have parameter LAP_W, default 8: width of lap_count.
REQ-002 SHALL have parameter DWELL_MAX, default 4: the stall check fires when one state is held for more than this many consecutive sampled cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port state_in, input, 4: one-hot state vector from the upstream 4-state ring FSM.
REQ-006 SHALL have port out_in, input, 2: encoded output from the upstream FSM.
REQ-007 SHALL have port clear, input, 1: synchronous soft clear of errors and counters.
REQ-008 SHALL have port mon_state, output, 2: monitor state; 00 SYNC, 01 RUN, 10 FAULT.
REQ-009 SHALL have port err, output, 1: sticky error flag.
REQ-010 SHALL have port err_code, output, 3: code of the first error.
REQ-011 SHALL have port lap_count, output, LAP_W: count of completed rings, saturating.

Function
REQ-012 SHALL treat 0001, 0010, 0100 and 1000 as legal states, with expected out_in 00, 01, 10 and 11 respectively.
REQ-013 SHALL use rotate-left as the legal successor (0001->0010->0100->1000->0001); holding the same state is also legal.
REQ-014 SHALL, in SYNC, move to RUN on the next edge after sampling state_in=0001 with out_in=00, and perform no checks while in SYNC.
REQ-015 SHALL, in RUN, check every sample against the registered previous sample; the first cycle in RUN compares against 0001.
REQ-016 SHALL use these error codes, with priority in this order when several apply in one cycle: 001 not exactly one bit set; 010 illegal transition; 011 out_in mismatch; 100 stall.
REQ-017 SHALL, on an error in RUN, go to FAULT on the next edge, with err=1 and err_code latched in that same cycle (latency one cycle).
REQ-018 SHALL hold FAULT, err and err_code until clear or reset, and ignore later errors while in FAULT.
REQ-019 SHALL increment lap_count on each sampled 1000->0001 transition in RUN, saturating at all-ones.
REQ-020 SHALL freeze lap_count in FAULT and in SYNC.
REQ-021 SHALL keep a dwell counter that resets on every state change and raises the stall error when the held count exceeds DWELL_MAX.
REQ-022 SHALL, on clear, go to SYNC and zero err, err_code, lap_count and the dwell counter on the next edge.
REQ-023 SHALL let clear win over an error detected in the same cycle.
REQ-024 SHALL let reset win over clear.
REQ-025 SHALL treat a 1000->0001 transition that also has an out_in mismatch as an error without counting a lap.

Reset
REQ-026 SHALL, on reset, set mon_state=00, err=0, err_code=000, lap_count=0, the dwell counter to 0 and the previous state register to 0001.
REQ-027 SHALL, when reset is asserted mid-operation, abandon all tracking and restart in SYNC.

Configuration
REQ-028 SHALL compile the stall/dwell check only when ONEHOT_MON_STALL_EN is defined.
REQ-029 SHALL, without ONEHOT_MON_STALL_EN, never produce err_code 100, ignore DWELL_MAX and build no dwell counter logic.

Verification
REQ-030 Reset for 1 cycle, then a clean ring 0001/00 -> 0010/01 -> 0100/10 -> 1000/11 for 3 laps -> mon_state=01, err=0, lap_count=3.
REQ-031 In RUN, drive state_in=0110 -> err=1 and err_code=001 one cycle later, mon_state=10; a later 0001 leaves err_code unchanged.
REQ-032 In RUN, jump 0010 -> 1000 with correct out_in -> err_code=010.
REQ-033 In RUN, drive 0100 with out_in=01 -> err_code=011.
REQ-034 With ONEHOT_MON_STALL_EN, hold 0010 for 6 samples -> err_code=100; without the macro -> err=0.
REQ-035 In FAULT, assert clear for 1 cycle -> mon_state=00 and lap_count=0; clear and an error in the same cycle -> err=0; after clear, resync on 0001.
